branch_resolve_unit: RTL and testbench

// - Multi-channel, 2-stage pipelined branch resolver for the OoO core: per channel, evaluates the

---
 rtl/branch_resolve_unit.sv | 179 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Two-stage, multi-channel branch resolver: condition, target, link, mispredict.
// Optional BRU_PERF_CNT_EN adds saturating resolved/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 2,
  parameter int TAG_W  = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*XLEN-1:0]  in_rs1,
  input  logic [NUM_CH*XLEN-1:0]  in_rs2,
  input  logic [NUM_CH*3-1:0]     in_func,
  input  logic [NUM_CH*XLEN-1:0]  in_pc,
  input  logic [NUM_CH*XLEN-1:0]  in_imm,
  input  logic [NUM_CH-1:0]       in_pred_taken,
  input  logic [NUM_CH*XLEN-1:0]  in_pred_target,
  input  logic [NUM_CH*TAG_W-1:0] in_tag,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH-1:0]       out_take,
  output logic [NUM_CH*XLEN-1:0]  out_target,
  output logic [NUM_CH*XLEN-1:0]  out_link,
  output logic [NUM_CH-1:0]       out_mispredict,
  output logic [NUM_CH*TAG_W-1:0] out_tag
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]             perf_resolved,
  output logic [31:0]             perf_mispred
`endif
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [XLEN-1:0]  rs1, rs2, pc, imm, ptgt;
    logic [2:0]       func;
    logic [TAG_W-1:0] tag;
    logic             pt;

    assign rs1  = in_rs1[c*XLEN +: XLEN];
    assign rs2  = in_rs2[c*XLEN +: XLEN];
    assign pc   = in_pc[c*XLEN +: XLEN];
    assign imm  = in_imm[c*XLEN +: XLEN];
    assign ptgt = in_pred_target[c*XLEN +: XLEN];
    assign func = in_func[c*3 +: 3];
    assign tag  = in_tag[c*TAG_W +: TAG_W];
    assign pt   = in_pred_taken[c];

    logic take_d;

    // Direction decision on the raw operands, captured into S1
    always_comb begin
      take_d = 1'b0;
      unique case (func)
        3'b000:  take_d = (rs1 == rs2);
        3'b001:  take_d = (rs1 != rs2);
        3'b010:  take_d = ($signed(rs1) < $signed(rs2));
        3'b011:  take_d = ($signed(rs1) >= $signed(rs2));
        3'b100:  take_d = (rs1 < rs2);
        3'b101:  take_d = (rs1 >= rs2);
        default: take_d = 1'b1;
      endcase
    end

    logic             s1_valid, s1_take, s1_jalr, s1_pt;
    logic [XLEN-1:0]  s1_rs1, s1_pc, s1_imm, s1_ptgt;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid, s2_take, s2_mis;
    logic [XLEN-1:0]  s2_target, s2_link;
    logic [TAG_W-1:0] s2_tag;

    logic s2_adv, s1_adv;
    assign s2_adv = !s2_valid || out_ready[c];
    assign s1_adv = !s1_valid || s2_adv;

    logic [XLEN-1:0] jalr_sum, taken_tgt;
    logic [XLEN-1:0] nxt_tgt, nxt_link;
    logic            nxt_mis;

    // Target/link/mispredict from S1 contents, wrapping mod 2^XLEN
    always_comb begin
      jalr_sum  = s1_rs1 + s1_imm;
      nxt_link  = s1_pc + XLEN'(4);
      taken_tgt = s1_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                          : s1_pc + s1_imm;
      nxt_tgt   = s1_take ? taken_tgt : nxt_link;
      nxt_mis   = (s1_take != s1_pt) ||
                  (s1_take && (nxt_tgt != s1_ptgt));
    end

    // Pipeline registers; reset beats flush, flush only kills valids
    always_ff @(posedge clock) begin
      if (reset) begin
        s1_valid  <= 1'b0;
        s1_take   <= 1'b0;
        s1_jalr   <= 1'b0;
        s1_pt     <= 1'b0;
        s1_rs1    <= '0;
        s1_pc     <= '0;
        s1_imm    <= '0;
        s1_ptgt   <= '0;
        s1_tag    <= '0;
        s2_valid  <= 1'b0;
        s2_take   <= 1'b0;
        s2_mis    <= 1'b0;
        s2_target <= '0;
        s2_link   <= '0;
        s2_tag    <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_take   <= s1_take;
            s2_mis    <= nxt_mis;
            s2_target <= nxt_tgt;
            s2_link   <= nxt_link;
            s2_tag    <= s1_tag;
          end
        end
        if (s1_adv) begin
          s1_valid <= in_valid[c];
          if (in_valid[c]) begin
            s1_take <= take_d;
            s1_jalr <= (func == 3'b111);
            s1_pt   <= pt;
            s1_rs1  <= rs1;
            s1_pc   <= pc;
            s1_imm  <= imm;
            s1_ptgt <= ptgt;
            s1_tag  <= tag;
          end
        end
      end
    end

    assign in_ready[c]                  = s1_adv;
    assign out_valid[c]                 = s2_valid;
    assign out_take[c]                  = s2_take;
    assign out_mispredict[c]            = s2_mis;
    assign out_target[c*XLEN +: XLEN]   = s2_target;
    assign out_link[c*XLEN +: XLEN]     = s2_link;
    assign out_tag[c*TAG_W +: TAG_W]    = s2_tag;
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] n_res, n_mis;
  logic [32:0] sum_res, sum_mis;

  // Per-cycle transfer counts across channels, with saturating sums
  always_comb begin
    n_res = '0;
    n_mis = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_res = n_res + {31'b0, out_valid[i] & out_ready[i]};
      n_mis = n_mis + {31'b0, out_valid[i] & out_ready[i]
                              & out_mispredict[i]};
    end
    sum_res = {1'b0, perf_resolved} + {1'b0, n_res};
    sum_mis = {1'b0, perf_mispred} + {1'b0, n_mis};
  end

  // Counters ignore transfers that coincide with a flush
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_resolved <= '0;
      perf_mispred  <= '0;
    end else if (!flush) begin
      perf_resolved <= sum_res[32] ? 32'hFFFF_FFFF : sum_res[31:0];
      perf_mispred  <= sum_mis[32] ? 32'hFFFF_FFFF : sum_mis[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (2 channels, XLEN 32, TAG_W 5).
// Hand-computed vectors for compare, target, backpressure, flush, reset.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int NCH  = 2;
  localparam int TW   = 5;

  logic clock = 1'b0;
  logic reset, flush;
  logic [NCH-1:0]      in_valid, in_ready;
  logic [NCH*XLEN-1:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
  logic [NCH*3-1:0]    in_func;
  logic [NCH-1:0]      in_pred_taken;
  logic [NCH*TW-1:0]   in_tag;
  logic [NCH-1:0]      out_valid, out_ready, out_take, out_mispredict;
  logic [NCH*XLEN-1:0] out_target, out_link;
  logic [NCH*TW-1:0]   out_tag;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_resolved, perf_mispred;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_resolve_unit #(.XLEN(XLEN), .NUM_CH(NCH), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func(in_func),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_take(out_take), .out_target(out_target),
    .out_link(out_link), .out_mispredict(out_mispredict),
    .out_tag(out_tag)
`ifdef BRU_PERF_CNT_EN
    , .perf_resolved(perf_resolved), .perf_mispred(perf_mispred)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_func = '0;
    in_pc = '0; in_imm = '0; in_pred_taken = '0;
    in_pred_target = '0; in_tag = '0;
  endtask

  task automatic drive(input int ch, input logic [2:0] f,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt,
                       input logic [4:0] tg);
    in_valid[ch]           = 1'b1;
    in_func[ch*3 +: 3]     = f;
    in_rs1[ch*32 +: 32]    = rs1;
    in_rs2[ch*32 +: 32]    = rs2;
    in_pc[ch*32 +: 32]     = pc;
    in_imm[ch*32 +: 32]    = imm;
    in_pred_taken[ch]      = pt;
    in_pred_target[ch*32 +: 32] = ptgt;
    in_tag[ch*TW +: TW]    = tg;
  endtask

  task automatic run1(input string nm, input int ch, input logic [2:0] f,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic pt, input logic [31:0] ptgt,
                      input logic [4:0] tg, input logic et,
                      input logic [31:0] etgt, input logic [31:0] elink,
                      input logic em);
    idle();
    out_ready = '1;
    drive(ch, f, rs1, rs2, pc, imm, pt, ptgt, tg);
    tick();
    idle();
    chk({nm, ".lat"}, {31'b0, out_valid[ch]}, 32'd0);
    tick();
    chk({nm, ".vld"}, {31'b0, out_valid[ch]}, 32'd1);
    chk({nm, ".take"}, {31'b0, out_take[ch]}, {31'b0, et});
    chk({nm, ".tgt"}, out_target[ch*32 +: 32], etgt);
    chk({nm, ".link"}, out_link[ch*32 +: 32], elink);
    chk({nm, ".mis"}, {31'b0, out_mispredict[ch]}, {31'b0, em});
    chk({nm, ".tag"}, {27'b0, out_tag[ch*TW +: TW]}, {27'b0, tg});
    tick();
  endtask

  task automatic zero_outs(input string nm);
    chk({nm, ".vld"}, {30'b0, out_valid}, 32'd0);
    chk({nm, ".take"}, {30'b0, out_take}, 32'd0);
    chk({nm, ".mis"}, {30'b0, out_mispredict}, 32'd0);
    chk({nm, ".tgt0"}, out_target[31:0], 32'd0);
    chk({nm, ".tgt1"}, out_target[63:32], 32'd0);
    chk({nm, ".lnk0"}, out_link[31:0], 32'd0);
    chk({nm, ".lnk1"}, out_link[63:32], 32'd0);
    chk({nm, ".tag"}, {22'b0, out_tag}, 32'd0);
  endtask

  int sent, recv, seen;
  logic rdy;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = '0;
    idle();
    tick(); tick();
    zero_outs("rst");
    chk("rst.rdy", {30'b0, in_ready}, 32'd3);
`ifdef BRU_PERF_CNT_EN
    chk("rst.pres", perf_resolved, 32'd0);
`endif
    reset = 1'b0;
    tick();

    run1("blt", 0, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20,
         1'b0, 32'h0, 5'd3, 1'b1, 32'h120, 32'h104, 1'b1);
    run1("bltu", 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20,
         1'b0, 32'h0, 5'd4, 1'b0, 32'h104, 32'h104, 1'b0);
`ifdef BRU_PERF_CNT_EN
    chk("perf.res2", perf_resolved, 32'd2);
    chk("perf.mis1", perf_mispred, 32'd1);
`endif
    run1("jalr.ok", 0, 3'b111, 32'h1001, 32'h0, 32'h200, 32'h4,
         1'b1, 32'h1004, 5'd7, 1'b1, 32'h1004, 32'h204, 1'b0);
    run1("jalr.bad", 1, 3'b111, 32'h1001, 32'h0, 32'h200, 32'h4,
         1'b1, 32'h1008, 5'd8, 1'b1, 32'h1004, 32'h204, 1'b1);
    run1("beq", 1, 3'b000, 32'd5, 32'd5, 32'h40, 32'hFFFF_FFF8,
         1'b1, 32'h38, 5'd9, 1'b1, 32'h38, 32'h44, 1'b0);
    run1("bne", 1, 3'b001, 32'd5, 32'd5, 32'h40, 32'hFFFF_FFF8,
         1'b1, 32'h38, 5'd10, 1'b0, 32'h44, 32'h44, 1'b1);
    run1("bge", 0, 3'b011, 32'd1, 32'hFFFF_FFFF, 32'h1000, 32'h10,
         1'b1, 32'h1010, 5'd11, 1'b1, 32'h1010, 32'h1004, 1'b0);
    run1("bgeu", 0, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h1000, 32'h10,
         1'b1, 32'h1010, 5'd12, 1'b0, 32'h1004, 32'h1004, 1'b1);
    run1("jal", 1, 3'b110, 32'd0, 32'd0, 32'h80, 32'h100,
         1'b1, 32'h184, 5'd13, 1'b1, 32'h180, 32'h84, 1'b1);
    run1("jal.wrap", 1, 3'b110, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20,
         1'b1, 32'h10, 5'd14, 1'b1, 32'h10, 32'hFFFF_FFF4, 1'b0);

    // ch0 stalled stream of 4, ch1 runs alongside
    idle();
    out_ready = 2'b10;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 3'b000, 32'd1, 32'd1, 32'h100 * (sent + 1), 32'h8,
            1'b1, 32'h100 * (sent + 1) + 32'h8, 5'(10 + sent));
      if (c == 0)
        drive(1, 3'b001, 32'd1, 32'd2, 32'h500, 32'h40,
              1'b0, 32'h0, 5'd21);
      else
        in_valid[1] = 1'b0;
      #1;
      rdy = in_ready[0];
      chk($sformatf("stall.rdy%0d", c), {31'b0, rdy},
          (c < 2) ? 32'd1 : 32'd0);
      if (c == 2) begin
        chk("ch1.vld", {31'b0, out_valid[1]}, 32'd1);
        chk("ch1.tag", {27'b0, out_tag[9:5]}, 32'd21);
        chk("ch1.tgt", out_target[63:32], 32'h540);
      end
      tick();
      if (rdy) sent++;
    end
    chk("stall.sent", sent, 32'd2);
    chk("stall.vld", {31'b0, out_valid[0]}, 32'd1);
    chk("stall.tag", {27'b0, out_tag[4:0]}, 32'd10);

    out_ready = 2'b11;
    recv = 0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 4)
        drive(0, 3'b000, 32'd1, 32'd1, 32'h100 * (sent + 1), 32'h8,
              1'b1, 32'h100 * (sent + 1) + 32'h8, 5'(10 + sent));
      else
        in_valid[0] = 1'b0;
      #1;
      rdy = in_valid[0] & in_ready[0];
      if (out_valid[0]) begin
        chk($sformatf("strm.tag%0d", recv), {27'b0, out_tag[4:0]},
            32'(10 + recv));
        chk($sformatf("strm.tgt%0d", recv), out_target[31:0],
            32'h100 * (recv + 1) + 32'h8);
        recv++;
      end
      tick();
      if (rdy) sent++;
    end
    chk("strm.recv", recv, 32'd4);
    chk("strm.ch1", {31'b0, out_valid[1]}, 32'd0);

    // flush with both stages full plus a live input
    idle();
    out_ready = '0;
    for (int c = 0; c < 2; c++) begin
      drive(0, 3'b110, 0, 0, 32'h40 * c, 32'h4, 1'b1, 0, 5'(c + 1));
      drive(1, 3'b110, 0, 0, 32'h80 * c, 32'h4, 1'b1, 0, 5'(c + 4));
      tick();
    end
    chk("fl.full", {30'b0, in_ready}, 32'd0);
    out_ready = '1;
    flush = 1'b1;
    drive(0, 3'b110, 0, 0, 32'h900, 32'h4, 1'b1, 0, 5'd31);
    drive(1, 3'b110, 0, 0, 32'h900, 32'h4, 1'b1, 0, 5'd30);
    #1;
    chk("fl.rdy", {30'b0, in_ready}, 32'd3);
    tick();
    flush = 1'b0;
    idle();
    chk("fl.vld", {30'b0, out_valid}, 32'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid != 0) seen++;
      tick();
    end
    chk("fl.drop", seen, 32'd0);

    // reset mid-stream
    out_ready = '0;
    for (int c = 0; c < 2; c++) begin
      drive(0, 3'b110, 0, 0, 32'h40, 32'h4, 1'b1, 0, 5'd17);
      drive(1, 3'b110, 0, 0, 32'h80, 32'h4, 1'b0, 0, 5'd18);
      tick();
    end
    chk("mr.pre", {30'b0, out_valid}, 32'd3);
    reset = 1'b1;
    tick();
    zero_outs("mrst");
`ifdef BRU_PERF_CNT_EN
    chk("mrst.pres", perf_resolved, 32'd0);
    chk("mrst.pmis", perf_mispred, 32'd0);
`endif
    reset = 1'b0;
    idle();
    tick();
    run1("wrap", 0, 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40,
         1'b0, 32'h0, 5'd5, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end
endmodule
